// File: rtl/rs_load_param.sv
// Parametrised load reservation station: CDB snoop, internal base+offset,
// oldest-first dispatch to memory. Optional flush input via RS_LOAD_FLUSH_EN.

module rs_load_entry #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int ROB_W  = 2,
  parameter int MY_TAG = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              alloc,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_offset,
  input  logic [ROB_W-1:0]  issue_rob,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              sent,
  input  logic              free,
  output logic              is_free,
  output logic              is_ready,
  output logic [DATA_W-1:0] addr,
  output logic [ROB_W-1:0]  rob
);
  typedef enum logic [2:0] {S_FREE, S_WAIT, S_CALC, S_READY, S_SENT} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] base_q, base_d, off_q, off_d, addr_q, addr_d;
  logic [TAG_W-1:0]  qj_q, qj_d;
  logic [ROB_W-1:0]  rob_q, rob_d;
  logic              cdb_ok;

  // A broadcast carrying this entry's own tag is never a wakeup for it.
  assign cdb_ok = cdb_valid && (cdb_tag != TAG_W'(MY_TAG));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    off_d   = off_q;
    addr_d  = addr_q;
    qj_d    = qj_q;
    rob_d   = rob_q;
    unique case (state_q)
      S_FREE: if (alloc) begin
        base_d  = issue_vj;
        off_d   = issue_offset;
        rob_d   = issue_rob;
        qj_d    = issue_qj;
        state_d = S_CALC;
        if (issue_qj != '0) begin
          if (cdb_ok && cdb_tag == issue_qj) begin
            base_d = cdb_data;
            qj_d   = '0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: if (cdb_ok && cdb_tag == qj_q) begin
        base_d  = cdb_data;
        qj_d    = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        addr_d  = base_q + off_q;
        state_d = S_READY;
      end
      S_READY: if (sent) state_d = S_SENT;
      default: ;
    endcase
    // Release beats any handshake on the same entry.
    if (free) begin
      state_d = S_FREE;
      base_d  = '0;
      off_d   = '0;
      addr_d  = '0;
      qj_d    = '0;
      rob_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q <= S_FREE;
      base_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      qj_q    <= '0;
      rob_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      qj_q    <= qj_d;
      rob_q   <= rob_d;
    end
  end

  assign is_free  = (state_q == S_FREE);
  assign is_ready = (state_q == S_READY);
  assign addr     = addr_q;
  assign rob      = rob_q;
endmodule

module rs_load_param #(
  parameter int DEPTH    = 3,
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 6,
  parameter int ROB_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef RS_LOAD_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       issue_valid,
  output logic                       issue_ready,
  output logic [TAG_W-1:0]           issue_tag,
  input  logic [DATA_W-1:0]          issue_vj,
  input  logic [TAG_W-1:0]           issue_qj,
  input  logic [DATA_W-1:0]          issue_offset,
  input  logic [ROB_W-1:0]           issue_rob,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [DATA_W-1:0]          mem_addr,
  output logic [TAG_W-1:0]           mem_tag,
  output logic [ROB_W-1:0]           mem_rob,
  input  logic                       free_valid,
  input  logic [TAG_W-1:0]           free_tag,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic                             flush_w, accept;
  logic [DEPTH-1:0]                 free_vec, ready_vec, alloc_vec, free_hit, sent_vec, sel_vec;
  logic [DEPTH-1:0][DATA_W-1:0]     addr_vec;
  logic [DEPTH-1:0][ROB_W-1:0]      rob_vec;
  // older_q[i][j] set: entry j was allocated before entry i.
  logic [DEPTH-1:0][DEPTH-1:0]      older_q, older_d;
  logic [OCC_W-1:0]                 occ;

`ifdef RS_LOAD_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign free_hit[gi] = free_valid && (free_tag != '0) && (free_tag == TAG_W'(TAG_BASE + gi));
    rs_load_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W), .ROB_W(ROB_W), .MY_TAG(TAG_BASE + gi)) u_ent (
      .clk(clk), .rst_n(rst_n), .clr(flush_w), .alloc(alloc_vec[gi]),
      .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_offset(issue_offset), .issue_rob(issue_rob),
      .cdb_valid(cdb_valid && !flush_w), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .sent(sent_vec[gi]), .free(free_hit[gi] && !flush_w),
      .is_free(free_vec[gi]), .is_ready(ready_vec[gi]), .addr(addr_vec[gi]), .rob(rob_vec[gi])
    );
  end

  assign busy        = (occ == OCC_W'(DEPTH));
  assign issue_ready = !busy;
  assign occupancy   = occ;
  assign accept      = issue_valid && issue_ready && !flush_w;

  always_comb begin
    logic found;
    found     = 1'b0;
    alloc_vec = '0;
    issue_tag = '0;
    occ       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!free_vec[i]) occ = occ + OCC_W'(1);
      if (free_vec[i] && !found) begin
        found        = 1'b1;
        alloc_vec[i] = accept;
        issue_tag    = TAG_W'(TAG_BASE + i);
      end
    end
  end

  always_comb begin
    sel_vec  = '0;
    mem_addr = '0;
    mem_tag  = '0;
    mem_rob  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_vec[i] = ready_vec[i] && ((older_q[i] & ready_vec) == '0);
      if (sel_vec[i]) begin
        mem_addr = addr_vec[i];
        mem_tag  = TAG_W'(TAG_BASE + i);
        mem_rob  = rob_vec[i];
      end
    end
  end

  assign mem_valid = (|sel_vec) && !flush_w;
  assign sent_vec  = sel_vec & {DEPTH{mem_ready && !flush_w}};

  // A new entry is younger than everything occupied before the edge.
  always_comb begin
    older_d = older_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (alloc_vec[k]) begin
        older_d[k] = ~free_vec;
        for (int j = 0; j < DEPTH; j++) older_d[j][k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_w) older_q <= '0;
    else                   older_q <= older_d;
  end
endmodule

// File: doc/rs_load_param.md
Name: rs_load_param

Overview:
- Parametrised load reservation station for the Tomasulo core; successor to the fixed 3-entry load RS.
- Holds DEPTH load entries and snoops the CDB for a pending base operand.
- Computes each effective address (base + offset) internally.
- Dispatches ready loads oldest-first to the memory unit over a valid/ready handshake, and releases entries on a free command from writeback.

Parameters:
- DEPTH, 3, number of entries (1..8)
- DATA_W, 64, operand/address/offset width
- TAG_W, 4, tag width; tag 0 = "no tag / value valid"
- TAG_BASE, 6, tag of entry 0; entry i owns tag TAG_BASE+i (TAG_BASE+DEPTH-1 < 2^TAG_W)
- ROB_W, 2, ROB index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- issue_valid  in  1  dispatcher presents a load
- issue_ready  out  1  a free entry exists (registered state only)
- issue_tag  out  TAG_W  tag the next accepted load receives; 0 when full
- issue_vj  in  DATA_W  base operand value
- issue_qj  in  TAG_W  producer tag of base; 0 = vj valid
- issue_offset  in  DATA_W  immediate offset
- issue_rob  in  ROB_W  destination ROB slot
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB producer tag
- cdb_data  in  DATA_W  CDB value
- mem_valid  out  1  an entry is READY and presented
- mem_ready  in  1  memory unit accepts
- mem_addr  out  DATA_W  effective address
- mem_tag  out  TAG_W  entry tag
- mem_rob  out  ROB_W  entry ROB slot
- free_valid  in  1  release an entry
- free_tag  in  TAG_W  tag to release
- busy  out  1  all entries occupied
- occupancy  out  $clog2(DEPTH+1)  number of non-FREE entries

Behaviour:
- Reset (rst_n=0 at posedge): all entries FREE, all stored fields 0, age order cleared. Outputs then: issue_ready=1, issue_tag=TAG_BASE, mem_valid=0, mem_addr/mem_tag/mem_rob=0, busy=0, occupancy=0. Reset mid-operation discards all entries; no handshake completes in the reset cycle.
- Per-entry FSM: FREE -> WAIT (qj!=0) or CALC (qj==0) -> READY -> SENT -> FREE.
- Allocation:
  - Accept when issue_valid && issue_ready; lowest-index FREE entry is used; issue_tag shows that entry's tag.
  - If issue_qj!=0 and cdb_valid && cdb_tag==issue_qj in the same cycle, capture cdb_data and enter CALC (bypass).
- WAIT: on cdb_valid && cdb_tag==stored qj, latch cdb_data into base, clear qj, go to CALC. One broadcast may wake several entries.
- CALC: one cycle. A <= base + offset, modulo 2^DATA_W (carry dropped). Then go to READY.
- Latency: accepted with qj==0 at edge N -> CALC after N -> READY after N+1 -> mem_valid high during cycle N+2.
- Arbitration:
  - Among READY entries, present the oldest by allocation order (not index).
  - Outputs are combinational from registered state.
  - Selection stays stable while mem_valid && !mem_ready unless an older entry becomes READY; mem_addr/tag/rob always match the selected entry.
  - Handshake (mem_valid && mem_ready) moves that entry READY -> SENT.
- Free:
  - free_valid with free_tag in [TAG_BASE, TAG_BASE+DEPTH-1] returns that entry to FREE from any state.
  - Out-of-range or 0 tags are ignored.
  - A freed slot is not re-allocatable in the same cycle, because issue_ready uses pre-edge state.
- Simultaneous events:
  - Free and handshake on the same entry: free wins.
  - Issue plus free in one cycle: both take effect; occupancy changes by net 0.
  - A CDB tag matching an entry's own tag is ignored.
- busy = (occupancy == DEPTH). issue_ready = !busy.

Optional Feature:
- Macro RS_LOAD_FLUSH_EN. When defined, adds input flush (1 bit).
- flush=1 at posedge: all entries FREE next cycle, same as reset but rst_n is not required.
- flush has priority over issue/CDB/free in that cycle; mem_valid is forced to 0 during the flush cycle.
- Without the macro, the port does not exist and the only clear mechanisms are rst_n and free.

Test Plan:
- Reset then issue vj=0x100, qj=0, offset=0x20, rob=2 -> issue_tag=6; mem_valid rises 2 cycles later with mem_addr=0x120, mem_tag=6, mem_rob=2.
- Issue qj=4 (waits); 3 cycles later cdb_valid, tag=4, data=0x1000; offset=8 -> mem_addr=0x1008 two cycles after broadcast.
- Bypass: issue qj=5 with cdb_valid, cdb_tag=5, data=0x40 same cycle, offset=4 -> mem_addr=0x44 at N+2, no WAIT.
- Fill 3 entries with qj=0 while mem_ready=0 -> busy=1, issue_ready=0, issue_tag=0, occupancy=3; mem_tag stays 6 (oldest).
  - Then mem_ready=1 -> tags sent in order 6, 7, 8.
- Free tag 7, then reissue -> lands in entry 1 (tag 7) but is younger than 8.
  - With 7 and 8 both READY, 8 dispatches first.
- Wrap: vj=0xFFFF_FFFF_FFFF_FFF0, offset=0x20 -> mem_addr=0x10. Assert rst_n=0 while entries are WAIT -> all outputs at reset values next cycle.
